traffic_phase_scheduler: RTL

Demand-driven phase scheduler for a two-way (NS/EW) intersection. It shares the intersection between vehicle detectors, latched pedestrian buttons and an emergency-preemption input, and sequences green, yellow and all-red clearance with min/max green limits. It is the next-generation replacement for the fixed-time light sequencer and drives the lamp and walk outputs directly.

---
 rtl/traffic_phase_scheduler_pkg.sv | 44 ++++
 rtl/traffic_phase_scheduler_ped_latch.sv | 25 ++
 rtl/traffic_phase_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/traffic_phase_scheduler_pkg.sv
// traffic_pkg: definitions shared by the traffic phase scheduler and its sub-modules.
//   - one-hot lamp codes RED / YELLOW / GREEN
//   - phase_t state enum and its fixed encodings
//   - emergency direction codes DIR_NS / DIR_EW
//   - lamp decode helpers for each approach
package traffic_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    typedef enum logic [2:0] {
        NS_GREEN     = 3'd0,
        NS_YELLOW    = 3'd1,
        RED_AFTER_NS = 3'd2,
        EW_GREEN     = 3'd3,
        EW_YELLOW    = 3'd4,
        RED_AFTER_EW = 3'd5
    } phase_t;

    function automatic logic [2:0] lamp_ns(input phase_t p);
        case (p)
            NS_GREEN:  lamp_ns = GREEN;
            NS_YELLOW: lamp_ns = YELLOW;
            default:   lamp_ns = RED;
        endcase
    endfunction

    function automatic logic [2:0] lamp_ew(input phase_t p);
        case (p)
            EW_GREEN:  lamp_ew = GREEN;
            EW_YELLOW: lamp_ew = YELLOW;
            default:   lamp_ew = RED;
        endcase
    endfunction

    function automatic logic is_green(input phase_t p);
        is_green = (p == NS_GREEN) || (p == EW_GREEN);
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_ped_latch.sv
// ped_request_latch: holds a pedestrian request until that direction is served.
//   clk, reset : clock, asynchronous active-high reset
//   btn        : button level/pulse of any width, sampled every clock
//   grant      : one-cycle strobe on the edge entering this direction's green
//   pending    : latched request; a press in the grant cycle keeps it pending
module ped_request_latch
    import traffic_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic grant,
    output logic pending
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pending <= 1'b0;
        else if (btn)
            pending <= 1'b1;
        else if (grant)
            pending <= 1'b0;
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: demand-driven NS/EW phase sequencer with min/max green,
// fixed yellow and all-red clearance, latched pedestrian requests and emergency
// preemption.
//   clk, reset                 : clock, asynchronous active-high reset
//   tick                       : timebase enable; timers and state move only on tick
//   ns_req, ew_req             : vehicle detector levels
//   ped_ns_btn, ped_ew_btn     : pedestrian buttons
//   emerg_valid, emerg_dir     : emergency request level and direction (0=NS, 1=EW)
//   NS, EW                     : one-hot lamps (RED=100, YELLOW=010, GREEN=001)
//   walk_ns, walk_ew           : walk indications
//   ped_ns_pending, ped_ew_pending : latched pedestrian requests
//   phase                      : current state encoding
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned T_MIN_GREEN = 4,
    parameter int unsigned T_MAX_GREEN = 12,
    parameter int unsigned T_YELLOW    = 2,
    parameter int unsigned T_ALL_RED   = 1,
    parameter int unsigned T_WALK      = 3
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_ns_btn,
    input  logic       ped_ew_btn,
    input  logic       emerg_valid,
    input  logic       emerg_dir,
    output logic [2:0] NS,
    output logic [2:0] EW,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic       ped_ns_pending,
    output logic       ped_ew_pending,
    output logic [2:0] phase
);

    localparam int unsigned TW = $clog2(T_MAX_GREEN + 1);
    localparam int unsigned WW = (T_WALK > 1) ? $clog2(T_WALK) : 1;

    phase_t          st;
    phase_t          st_next;
    logic [TW-1:0]   timer;
    logic [WW-1:0]   walk_cnt;

    logic emerg_ns, emerg_ew;
    logic own_ns, own_ew;
    logic conf_ns, conf_ew;
    logic min_done, max_done;
    logic ns_exit, ew_exit;
    logic enter_ns, enter_ew;

    assign phase = st;

    // Demand terms and green exit decisions
    always_comb begin
        emerg_ns = emerg_valid & (emerg_dir == DIR_NS);
        emerg_ew = emerg_valid & (emerg_dir == DIR_EW);
        own_ns   = ns_req | emerg_ns;
        own_ew   = ew_req | emerg_ew;
        conf_ns  = ew_req | ped_ew_pending | emerg_ew;
        conf_ew  = ns_req | ped_ns_pending | emerg_ns;
        min_done = (timer >= TW'(T_MIN_GREEN - 1));
        max_done = (timer == TW'(T_MAX_GREEN - 1));
        // An emergency for the green direction pins it; an opposing one cuts it short.
        ns_exit  = !emerg_ns && (emerg_ew || (min_done && conf_ns && (!own_ns || max_done)));
        ew_exit  = !emerg_ew && (emerg_ns || (min_done && conf_ew && (!own_ew || max_done)));
    end

    always_comb begin
        st_next = st;
        case (st)
            NS_GREEN:     if (tick && ns_exit) st_next = NS_YELLOW;
            NS_YELLOW:    if (tick && timer == TW'(T_YELLOW - 1))  st_next = RED_AFTER_NS;
            RED_AFTER_NS: if (tick && timer == TW'(T_ALL_RED - 1)) st_next = EW_GREEN;
            EW_GREEN:     if (tick && ew_exit) st_next = EW_YELLOW;
            EW_YELLOW:    if (tick && timer == TW'(T_YELLOW - 1))  st_next = RED_AFTER_EW;
            RED_AFTER_EW: if (tick && timer == TW'(T_ALL_RED - 1)) st_next = NS_GREEN;
            default:      st_next = NS_GREEN;
        endcase
    end

    assign enter_ns = (st_next == NS_GREEN) && (st != NS_GREEN);
    assign enter_ew = (st_next == EW_GREEN) && (st != EW_GREEN);

    ped_request_latch u_ped_ns (
        .clk     (clk),
        .reset   (reset),
        .btn     (ped_ns_btn),
        .grant   (enter_ns),
        .pending (ped_ns_pending)
    );

    ped_request_latch u_ped_ew (
        .clk     (clk),
        .reset   (reset),
        .btn     (ped_ew_btn),
        .grant   (enter_ew),
        .pending (ped_ew_pending)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= NS_GREEN;
            timer    <= '0;
            walk_cnt <= '0;
            NS       <= GREEN;
            EW       <= RED;
            walk_ns  <= 1'b0;
            walk_ew  <= 1'b0;
        end else begin
            st <= st_next;
            NS <= lamp_ns(st_next);
            EW <= lamp_ew(st_next);

            if (st_next != st)
                timer <= '0;
            else if (tick && !max_done)
                timer <= timer + TW'(1);

            // A press in the entry cycle re-arms the latch, so it withholds walk now.
            if (enter_ns || enter_ew) begin
                walk_cnt <= '0;
                walk_ns  <= enter_ns & ped_ns_pending & ~ped_ns_btn;
                walk_ew  <= enter_ew & ped_ew_pending & ~ped_ew_btn;
            end else if (!is_green(st_next)) begin
                // Covers preemption: walk drops on the edge the green is abandoned.
                walk_ns <= 1'b0;
                walk_ew <= 1'b0;
            end else if (tick && (walk_ns || walk_ew)) begin
                if (walk_cnt == WW'(T_WALK - 1)) begin
                    walk_ns <= 1'b0;
                    walk_ew <= 1'b0;
                end else begin
                    walk_cnt <= walk_cnt + WW'(1);
                end
            end
        end
    end

endmodule
